// File: rtl/alu_seq_if.sv
// Bundle between the control unit, the sequencer and the shared 8-bit ALU.
// The slave side is the sequencer; the master side drives requests and the ALU result.
interface alu_seq_if #(
  parameter int OPW = 5
);
  logic           start;
  logic [1:0]     mop;
  logic [OPW-1:0] op_in;
  logic [7:0]     in_a;
  logic [7:0]     in_b;
  logic           busy;
  logic           done;
  logic [7:0]     result;
  logic [OPW-1:0] alu_op;
  logic [7:0]     alu_a;
  logic [7:0]     alu_b;
  logic [7:0]     alu_out;

  modport master (
    output start, mop, op_in, in_a, in_b,
    output alu_out,
    input  busy, done, result,
    input  alu_op, alu_a, alu_b
  );

  modport slave (
    input  start, mop, op_in, in_a, in_b,
    input  alu_out,
    output busy, done, result,
    output alu_op, alu_a, alu_b
  );
endinterface

// File: rtl/alu_seq.sv
// Macro-op sequencer: runs SINGLE, SHLN, SHRN and shift-add MUL
// on the shared single-cycle ALU, one opcode per clock.
module alu_seq #(
  parameter int             OPW    = 5,
  parameter logic [OPW-1:0] OP_ADD = 5'd0,
  parameter logic [OPW-1:0] OP_LSL = 5'd7,
  parameter logic [OPW-1:0] OP_LSR = 5'd8
) (
  input logic       clk,
  input logic       rst,
  alu_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    SINGLE,
    SHIFT,
    M_ADD,
    M_LSL,
    M_LSR,
    DONE
  } state_e;

  localparam logic [1:0] MOP_SINGLE = 2'b00;
  localparam logic [1:0] MOP_SHLN   = 2'b01;
  localparam logic [1:0] MOP_SHRN   = 2'b10;
  localparam logic [1:0] MOP_MUL    = 2'b11;

  state_e         state_q;
  logic [7:0]     a_q;
  logic [7:0]     b_q;
  logic [7:0]     p_q;
  logic [3:0]     cnt_q;
  logic [OPW-1:0] op_q;
  logic [1:0]     mop_q;
  logic [7:0]     result_q;

  logic [3:0] cnt_d;

  // shift counts above 8 all flush the operand to zero
  assign cnt_d = bus.in_b[3] ? 4'd8 : bus.in_b[3:0];

  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;

  always_comb begin
    bus.alu_op = OP_ADD;
    bus.alu_a  = 8'd0;
    bus.alu_b  = 8'd0;
    unique case (state_q)
      SINGLE: begin
        bus.alu_op = op_q;
        bus.alu_a  = a_q;
        bus.alu_b  = b_q;
      end
      SHIFT: begin
        bus.alu_op = (mop_q == MOP_SHRN) ? OP_LSR : OP_LSL;
        bus.alu_a  = a_q;
      end
      M_ADD: begin
        bus.alu_op = OP_ADD;
        bus.alu_a  = p_q;
        bus.alu_b  = a_q;
      end
      M_LSL: begin
        bus.alu_op = OP_LSL;
        bus.alu_a  = a_q;
      end
      M_LSR: begin
        bus.alu_op = OP_LSR;
        bus.alu_a  = b_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= 8'd0;
      b_q      <= 8'd0;
      p_q      <= 8'd0;
      cnt_q    <= 4'd0;
      op_q     <= '0;
      mop_q    <= 2'b00;
      result_q <= 8'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q   <= bus.in_a;
            b_q   <= bus.in_b;
            op_q  <= bus.op_in;
            mop_q <= bus.mop;
            p_q   <= 8'd0;
            cnt_q <= cnt_d;
            unique case (bus.mop)
              MOP_SINGLE: state_q <= SINGLE;
              MOP_SHLN, MOP_SHRN: begin
                if (cnt_d == 4'd0) begin
                  result_q <= bus.in_a;
                  state_q  <= DONE;
                end else begin
                  state_q <= SHIFT;
                end
              end
              MOP_MUL: begin
                if (bus.in_b == 8'd0) begin
                  result_q <= 8'd0;
                  state_q  <= DONE;
                end else if (bus.in_b[0]) begin
                  state_q <= M_ADD;
                end else begin
                  state_q <= M_LSL;
                end
              end
              default: state_q <= IDLE;
            endcase
          end
        end
        SINGLE: begin
          result_q <= bus.alu_out;
          state_q  <= DONE;
        end
        SHIFT: begin
          a_q   <= bus.alu_out;
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            result_q <= bus.alu_out;
            state_q  <= DONE;
          end
        end
        M_ADD: begin
          p_q     <= bus.alu_out;
          state_q <= M_LSL;
        end
        M_LSL: begin
          a_q     <= bus.alu_out;
          state_q <= M_LSR;
        end
        M_LSR: begin
          b_q <= bus.alu_out;
          // p_q already holds any add from this iteration
          if (bus.alu_out == 8'd0) begin
            result_q <= p_q;
            state_q  <= DONE;
          end else if (bus.alu_out[0]) begin
            state_q <= M_ADD;
          end else begin
            state_q <= M_LSL;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: behavioural ALU plus a reference model of
// each macro-op's result and opcode trace.
module tb_alu_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;

  alu_seq_if #(.OPW(5)) bus ();

  alu_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(logic [4:0] op, logic [7:0] a, logic [7:0] b);
    case (op)
      5'd0: return a + b;
      5'd1: return a - b;
      5'd2: return a & b;
      5'd3: return a | b;
      5'd4: return a ^ b;
      5'd7: return {a[6:0], 1'b0};
      5'd8: return {1'b0, a[7:1]};
      default: return a;
    endcase
  endfunction

  always_comb bus.alu_out = alu_f(bus.alu_op, bus.alu_a, bus.alu_b);

  logic [4:0] exp_ops[$];
  logic [4:0] obs_ops[$];
  logic [7:0] obs_res, obs_res_after, obs_a0, obs_b0;
  int         obs_cyc;
  bit         obs_to, obs_busy_done, obs_busy_after, obs_done_after;
  logic [4:0] opset[7] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd7, 5'd8};

  function automatic logic [7:0] ref_res(logic [1:0] m, logic [4:0] o, logic [7:0] a, logic [7:0] b);
    int n;
    int prod;
    n = b[3:0];
    case (m)
      2'd0: return alu_f(o, a, b);
      2'd1: return (n >= 8) ? 8'd0 : 8'((int'(a) << n) & 255);
      2'd2: return (n >= 8) ? 8'd0 : 8'(int'(a) >> n);
      default: begin
        prod = int'(a) * int'(b);
        return 8'(prod & 255);
      end
    endcase
  endfunction

  task automatic build_exp(input logic [1:0] m, input logic [4:0] o, input logic [7:0] b);
    int n;
    exp_ops.delete();
    n = (b[3:0] > 4'd8) ? 8 : int'(b[3:0]);
    case (m)
      2'd0: exp_ops.push_back(o);
      2'd1: for (int i = 0; i < n; i++) exp_ops.push_back(5'd7);
      2'd2: for (int i = 0; i < n; i++) exp_ops.push_back(5'd8);
      default:
        for (int i = 0; i < 8; i++)
          if ((int'(b) >> i) != 0) begin
            if (b[i]) exp_ops.push_back(5'd0);
            exp_ops.push_back(5'd7);
            exp_ops.push_back(5'd8);
          end
    endcase
  endtask

  function automatic bit ops_same();
    if (obs_ops.size() != exp_ops.size()) return 1'b0;
    foreach (obs_ops[i]) if (obs_ops[i] !== exp_ops[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run_op(input logic [1:0] m, input logic [4:0] o,
                        input logic [7:0] a, input logic [7:0] b, input bit noise);
    obs_ops.delete();
    obs_cyc = 0;
    obs_to  = 1'b1;
    @(negedge clk);
    bus.mop = m; bus.op_in = o; bus.in_a = a; bus.in_b = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done) begin
        obs_to = 1'b0;
        break;
      end
      if (obs_cyc == 0) begin
        obs_a0 = bus.alu_a;
        obs_b0 = bus.alu_b;
      end
      obs_ops.push_back(bus.alu_op);
      obs_cyc++;
      if (noise) begin
        bus.start = 1'($urandom);
        bus.mop   = 2'($urandom);
        bus.in_a  = 8'($urandom);
        bus.in_b  = 8'($urandom);
        bus.op_in = opset[$urandom_range(0, 6)];
      end
    end
    obs_res = bus.result;
    obs_busy_done = bus.busy;
    if (noise) bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    obs_busy_after = bus.busy;
    obs_done_after = bus.done;
    obs_res_after  = bus.result;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", bus.done); end
    total++; if (bus.result !== 8'h00) begin bad++; $display("FAIL rst_result got=%h want=00", bus.result); end
    total++; if ({bus.alu_op, bus.alu_a, bus.alu_b} !== 21'd0) begin
      bad++; $display("FAIL rst_alu got=%h/%h/%h want=0/0/0", bus.alu_op, bus.alu_a, bus.alu_b);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_single();
    run_op(2'd0, 5'd1, 8'h10, 8'h03, 1'b0);
    total++; if (obs_to || obs_cyc != 1) begin bad++; $display("FAIL single_cycles got=%0d to=%b want=1", obs_cyc, obs_to); end
    total++; if ({obs_ops[0], obs_a0, obs_b0} !== {5'd1, 8'h10, 8'h03}) begin
      bad++; $display("FAIL single_alu got=%h/%h/%h want=01/10/03", obs_ops[0], obs_a0, obs_b0);
    end
    total++; if (obs_res !== 8'h0D) begin bad++; $display("FAIL single_res got=%h want=0d", obs_res); end
    total++; if (obs_busy_done !== 1'b1 || obs_busy_after !== 1'b0 || obs_done_after !== 1'b0) begin
      bad++; $display("FAIL single_busy got=%b%b%b want=100", obs_busy_done, obs_busy_after, obs_done_after);
    end
    total++; if (obs_res_after !== 8'h0D) begin bad++; $display("FAIL single_hold got=%h want=0d", obs_res_after); end
  endtask

  task automatic test_shift();
    run_op(2'd1, 5'd0, 8'h81, 8'd3, 1'b0);
    build_exp(2'd1, 5'd0, 8'd3);
    total++; if (!ops_same() || obs_to) begin bad++; $display("FAIL shl_ops got=%0d cycles want=3", obs_cyc); end
    total++; if (obs_res !== 8'h08) begin bad++; $display("FAIL shl_res got=%h want=08", obs_res); end
    run_op(2'd2, 5'd0, 8'hF0, 8'd12, 1'b0);
    build_exp(2'd2, 5'd0, 8'd12);
    total++; if (!ops_same() || obs_to) begin bad++; $display("FAIL shr_clamp_ops got=%0d cycles want=8", obs_cyc); end
    total++; if (obs_res !== 8'h00) begin bad++; $display("FAIL shr_clamp_res got=%h want=00", obs_res); end
    run_op(2'd2, 5'd0, 8'h5A, 8'd0, 1'b0);
    total++; if (obs_to || obs_cyc != 0) begin bad++; $display("FAIL shr0_cycles got=%0d want=0", obs_cyc); end
    total++; if (obs_res !== 8'h5A) begin bad++; $display("FAIL shr0_res got=%h want=5a", obs_res); end
  endtask

  task automatic test_mul();
    logic [4:0] want[$] = '{5'd0, 5'd7, 5'd8, 5'd7, 5'd8, 5'd0, 5'd7, 5'd8};
    run_op(2'd3, 5'd0, 8'd3, 8'd5, 1'b0);
    exp_ops = want;
    total++; if (!ops_same() || obs_to) begin bad++; $display("FAIL mul35_ops got=%0d cycles want=8", obs_cyc); end
    total++; if (obs_res !== 8'h0F) begin bad++; $display("FAIL mul35_res got=%h want=0f", obs_res); end
    run_op(2'd3, 5'd0, 8'h10, 8'h11, 1'b0);
    total++; if (obs_res !== 8'h10) begin bad++; $display("FAIL mul_ovf_res got=%h want=10", obs_res); end
    run_op(2'd3, 5'd0, 8'h7F, 8'h00, 1'b0);
    total++; if (obs_to || obs_cyc != 0 || obs_res !== 8'h00) begin
      bad++; $display("FAIL mul_zero got=%h cyc=%0d want=00 cyc=0", obs_res, obs_cyc);
    end
  endtask

  task automatic test_ignore_start();
    run_op(2'd3, 5'd0, 8'd3, 8'd5, 1'b1);
    build_exp(2'd3, 5'd0, 8'd5);
    total++; if (!ops_same() || obs_to) begin bad++; $display("FAIL ign_ops got=%0d cycles want=%0d", obs_cyc, exp_ops.size()); end
    total++; if (obs_res !== 8'h0F || obs_res_after !== 8'h0F) begin
      bad++; $display("FAIL ign_res got=%h/%h want=0f", obs_res, obs_res_after);
    end
    total++; if (obs_busy_after !== 1'b0) begin bad++; $display("FAIL ign_idle got=%b want=0", obs_busy_after); end
    run_op(2'd1, 5'd0, 8'h03, 8'd2, 1'b0);
    total++; if (obs_res !== 8'h0C || obs_cyc != 2) begin
      bad++; $display("FAIL ign_next got=%h cyc=%0d want=0c cyc=2", obs_res, obs_cyc);
    end
  endtask

  task automatic test_async_reset();
    int seen;
    @(negedge clk);
    bus.mop = 2'd3; bus.in_a = 8'hFF; bus.in_b = 8'hFF; bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      bad++; $display("FAIL arst_bd got=%b%b want=00", bus.busy, bus.done);
    end
    total++; if (bus.result !== 8'h00) begin bad++; $display("FAIL arst_res got=%h want=00", bus.result); end
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL arst_nodone got=%0d want=0", seen); end
    run_op(2'd3, 5'd0, 8'd2, 8'd2, 1'b0);
    total++; if (obs_res !== 8'h04) begin bad++; $display("FAIL arst_mul got=%h want=04", obs_res); end
  endtask

  task automatic test_random();
    logic [1:0] m;
    logic [4:0] o;
    logic [7:0] a, b;
    logic [7:0] want;
    for (int i = 0; i < 40; i++) begin
      m = 2'($urandom);
      o = opset[$urandom_range(0, 6)];
      a = 8'($urandom);
      b = 8'($urandom);
      want = ref_res(m, o, a, b);
      build_exp(m, o, b);
      run_op(m, o, a, b, 1'($urandom));
      total++; if (obs_res !== want) begin
        bad++; $display("FAIL rnd_res m=%0d op=%0d a=%h b=%h got=%h want=%h", m, o, a, b, obs_res, want);
      end
      total++; if (!ops_same() || obs_to) begin
        bad++; $display("FAIL rnd_ops m=%0d a=%h b=%h got=%0d cycles want=%0d", m, a, b, obs_cyc, exp_ops.size());
      end
      total++; if (obs_busy_after !== 1'b0 || obs_res_after !== want) begin
        bad++; $display("FAIL rnd_after got=%b/%h want=0/%h", obs_busy_after, obs_res_after, want);
      end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.mop   = 2'd0;
    bus.op_in = 5'd0;
    bus.in_a  = 8'd0;
    bus.in_b  = 8'd0;
    test_reset();
    test_single();
    test_shift();
    test_mul();
    test_ignore_start();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Multi-cycle sequencer that owns the shared 8-bit single-cycle ALU and executes macro-operations by issuing one ALU opcode per clock.
- Supports a single pass-through ALU op, shift-left-by-N, shift-right-by-N, and 8x8 unsigned multiply (low byte) via shift-add.
- Sits between the core control unit (start/done handshake) and the ALU (drives its op and operand inputs, reads its result).

Parameters:
OPW, 5, ALU opcode width.
OP_ADD, 5'd0, ALU ADD encoding.
OP_LSL, 5'd7, ALU logical-shift-left-by-1 encoding.
OP_LSR, 5'd8, ALU logical-shift-right-by-1 encoding.

Ports:
Clk  in  1  system clock, rising edge.
Reset  in  1  asynchronous, active-high reset.
start  in  1  request pulse; sampled only in IDLE.
mop  in  2  macro op: 00 SINGLE, 01 SHLN, 10 SHRN, 11 MUL.
op_in  in  OPW  ALU opcode used by SINGLE.
in_a  in  8  operand A.
in_b  in  8  operand B (shift count in [3:0] for SHLN/SHRN).
busy  out  1  high from the cycle after start is accepted through the done cycle inclusive.
done  out  1  one-cycle completion pulse.
result  out  8  macro-op result; valid when done=1; held until the next accepted start.
alu_op  out  OPW  opcode to ALU.
alu_a  out  8  ALU InA.
alu_b  out  8  ALU InB.
alu_out  in  8  ALU Out (combinational).

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, result=0; internal a_r, b_r, p_r, cnt, op_r cleared. An operation in flight is abandoned with no done pulse.
- States: IDLE, SINGLE, SHIFT, M_ADD, M_LSL, M_LSR, DONE.
- In IDLE and DONE: alu_op=OP_ADD, alu_a=0, alu_b=0.
- Accept: at edge E0 with state=IDLE and start=1, latch a_r=in_a, b_r=in_b, op_r=op_in, p_r=0, cnt=min(in_b[3:0],8).
- start in any non-IDLE state, including DONE, is ignored.
- Each non-IDLE/non-DONE state is exactly one ALU cycle. The register update from alu_out occurs at the closing edge.
- SINGLE: drive alu_op=op_r, alu_a=a_r, alu_b=b_r; result<=alu_out; next state DONE. Done is high in the cycle after E1.
- SHLN/SHRN: SHIFT drives OP_LSL or OP_LSR with alu_a=a_r, alu_b=0; a_r<=alu_out; cnt decrements; leave SHIFT when cnt reaches 0. Result=a_r.
  - cnt=0 at accept: go straight to DONE, result=in_a, done in the cycle after E0.
  - Counts 8..15 are clamped to 8, giving result 0.
- MUL entry from IDLE: in_b=0 → DONE with result 0; in_b[0]=1 → M_ADD; otherwise M_LSL.
- M_ADD: alu_op=OP_ADD, alu_a=p_r, alu_b=a_r; p_r<=alu_out (mod 256) → M_LSL.
- M_LSL: alu_op=OP_LSL, alu_a=a_r; a_r<=alu_out → M_LSR.
- M_LSR: alu_op=OP_LSR, alu_a=b_r; b_r<=alu_out. Then:
  - alu_out=0 → DONE with result=p_r (including the final add);
  - else alu_out[0]=1 → M_ADD;
  - else → M_LSL.
- MUL termination and cost: at most 8 iterations, since b_r reaches zero. Each iteration costs 2 cycles, plus 1 when its b bit is 1. Overflow above bit 7 is discarded.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE. result is updated on entry to DONE and is stable afterwards.
- All outputs are registered-state decodes. alu_* are combinational from state and registers only, never from start.

Test Plan:
1. SINGLE op_in=5'd1 (SUB), in_a=0x10, in_b=0x03, start at E0 → one cycle with alu_op=1, alu_a=0x10, alu_b=0x03; done=1 in the cycle after E1; result=0x0D; busy=0 after.
2. SHLN in_a=0x81, in_b=3 → exactly 3 cycles of alu_op=OP_LSL; result=0x08. SHRN in_a=0xF0, in_b=12 → 8 LSR cycles, result=0x00.
3. SHRN in_b=0, in_a=0x5A → zero ALU cycles; done in the cycle after the accept edge; result=0x5A.
4. MUL 3×5 → alu_op sequence ADD,LSL,LSR,LSL,LSR,ADD,LSL,LSR (8 cycles); result=0x0F. MUL 0x10×0x11 → result=0x10 (overflow dropped). MUL 0x7F×0 → immediate done, result=0x00.
5. start pulsed during busy and during the DONE cycle → ignored; result, op sequence and cycle count unchanged; the next start in IDLE is accepted normally.
6. Reset asserted asynchronously mid-MUL (between edges) → busy=0, done=0, result=0 immediately. No done pulse follows. A fresh MUL 2×2 afterwards gives result=0x04.
